// File: rtl/data_mem_access_ctrl_pkg.sv
// Shared definitions for the doubleword data-memory access controller:
// funct3 encodings, FSM states, fault codes and the access-size decode.
package mem_access_pkg;

    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LD      = 3'b011;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_LWU     = 3'b110;
    localparam logic [2:0] F3_ILLEGAL = 3'b111;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE    = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        KIND_LOAD  = 1'b0,
        KIND_STORE = 1'b1
    } kind_t;

    // Access width in bytes from the low two funct3 bits: 1, 2, 4 or 8.
    function automatic logic [3:0] accessSize(input logic [1:0] sizeCode);
        logic [3:0] bytes;
        case (sizeCode)
            2'b00:   bytes = 4'd1;
            2'b01:   bytes = 4'd2;
            2'b10:   bytes = 4'd4;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/data_mem_access_ctrl_if.sv
// Doubleword data-memory bus: the controller is the master, the memory the slave.
interface data_mem_access_ctrl_if;

    logic [63:0] Mem_Addr;
    logic [63:0] WriteData;
    logic        Mem_MemRead;
    logic        Mem_MemWrite;
    logic [63:0] ReadData;

    modport master (
        output Mem_Addr,
        output WriteData,
        output Mem_MemRead,
        output Mem_MemWrite,
        input  ReadData
    );

    modport slave (
        input  Mem_Addr,
        input  WriteData,
        input  Mem_MemRead,
        input  Mem_MemWrite,
        output ReadData
    );

endinterface

// File: rtl/data_mem_access_ctrl_align.sv
// Combinational lane logic: extracts and extends a load field from a doubleword,
// and merges a sub-doubleword store into the doubleword read back from memory.
module mem_data_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] readData_i,
    input  logic [63:0] storeData_i,
    output logic [63:0] loadData_o,
    output logic [63:0] mergeData_o
);

    logic [5:0]  bitShift;
    logic [63:0] shifted;
    logic [63:0] fieldMask;

    assign bitShift = {offset_i, 3'b000};
    assign shifted  = readData_i >> bitShift;

    always_comb begin
        loadData_o = shifted;
        case (funct3_i)
            F3_LB:   loadData_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   loadData_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   loadData_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LBU:  loadData_o = {56'd0, shifted[7:0]};
            F3_LHU:  loadData_o = {48'd0, shifted[15:0]};
            F3_LWU:  loadData_o = {32'd0, shifted[31:0]};
            default: loadData_o = shifted;
        endcase
    end

    // Only the low bytes of the store source land in the addressed lanes.
    always_comb begin
        fieldMask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (funct3_i[1:0])
            2'b00:   fieldMask = 64'h0000_0000_0000_00FF;
            2'b01:   fieldMask = 64'h0000_0000_0000_FFFF;
            2'b10:   fieldMask = 64'h0000_0000_FFFF_FFFF;
            default: fieldMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        mergeData_o = (readData_i & ~(fieldMask << bitShift))
                    | ((storeData_i & fieldMask) << bitShift);
    end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// MEM-stage controller that turns RISC-V loads/stores of any width into aligned
// doubleword accesses, using read-modify-write for narrow stores.
module data_mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MEM_BYTES    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] Addr,
    input  logic [63:0] StoreData,
    output logic        Stall,
    output logic        Done,
    output logic [63:0] LoadData,
    output logic        Fault,
    output logic [1:0]  FaultCause,
    data_mem_access_ctrl_if.master mem
);

    localparam logic [3:0] LastCount = 4'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [63:0] memAddr_q, memAddr_d;
    logic [2:0]  offset_q, offset_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] storeData_q, storeData_d;
    kind_t       kind_q, kind_d;
    logic [63:0] writeData_q, writeData_d;
    logic [63:0] loadData_q, loadData_d;

    logic        request;
    logic [3:0]  sizeBytes;
    logic [2:0]  alignMask;
    logic [64:0] endAddr;
    logic        illegal;
    logic        outOfRange;
    logic        misaligned;
    logic [1:0]  reqCause;
    logic [63:0] alignedLoad;
    logic [63:0] mergedStore;

    mem_data_align uAlign (
        .offset_i    (offset_q),
        .funct3_i    (funct3_q),
        .readData_i  (mem.ReadData),
        .storeData_i (storeData_q),
        .loadData_o  (alignedLoad),
        .mergeData_o (mergedStore)
    );

    // The end address is formed one bit wider so huge addresses cannot wrap into range.
    always_comb begin
        request    = MemRead | MemWrite;
        sizeBytes  = accessSize(funct3[1:0]);
        alignMask  = 3'(sizeBytes - 4'd1);
        endAddr    = {1'b0, Addr} + {61'd0, sizeBytes};
        illegal    = (MemRead && MemWrite) || (funct3 == F3_ILLEGAL) || (MemWrite && funct3[2]);
        outOfRange = endAddr > 65'(MEM_BYTES);
        misaligned = (Addr[2:0] & alignMask) != 3'd0;
        reqCause   = CAUSE_NONE;
        if (illegal) begin
            reqCause = CAUSE_ILLEGAL;
        end else if (outOfRange) begin
            reqCause = CAUSE_RANGE;
        end else if (misaligned) begin
            reqCause = CAUSE_MISALIGN;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        memAddr_d   = memAddr_q;
        offset_d    = offset_q;
        funct3_d    = funct3_q;
        storeData_d = storeData_q;
        kind_d      = kind_q;
        writeData_d = writeData_q;
        loadData_d  = loadData_q;
        Stall       = 1'b0;
        Done        = 1'b0;
        Fault       = 1'b0;
        FaultCause  = CAUSE_NONE;

        case (state_q)
            IDLE: begin
                if (request && (reqCause != CAUSE_NONE)) begin
                    Fault      = 1'b1;
                    FaultCause = reqCause;
                end else if (request) begin
                    Stall       = 1'b1;
                    memAddr_d   = {Addr[63:3], 3'b000};
                    offset_d    = Addr[2:0];
                    funct3_d    = funct3;
                    storeData_d = StoreData;
                    kind_d      = MemWrite ? KIND_STORE : KIND_LOAD;
                    count_d     = 4'd0;
                    // A full doubleword store needs no read-back.
                    if (MemWrite && (funct3[1:0] == 2'b11)) begin
                        writeData_d = StoreData;
                        state_d     = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                Stall = 1'b1;
                if (count_q == LastCount) begin
                    count_d = 4'd0;
                    if (kind_q == KIND_LOAD) begin
                        loadData_d = alignedLoad;
                        state_d    = DONE;
                    end else begin
                        writeData_d = mergedStore;
                        state_d     = WR;
                    end
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            WR: begin
                Stall   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            memAddr_q   <= 64'd0;
            offset_q    <= 3'd0;
            funct3_q    <= 3'd0;
            storeData_q <= 64'd0;
            kind_q      <= KIND_LOAD;
            writeData_q <= 64'd0;
            loadData_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            memAddr_q   <= memAddr_d;
            offset_q    <= offset_d;
            funct3_q    <= funct3_d;
            storeData_q <= storeData_d;
            kind_q      <= kind_d;
            writeData_q <= writeData_d;
            loadData_q  <= loadData_d;
        end
    end

    assign mem.Mem_MemRead  = (state_q == RD);
    assign mem.Mem_MemWrite = (state_q == WR);
    assign mem.Mem_Addr     = memAddr_q;
    assign mem.WriteData    = writeData_q;
    assign LoadData         = loadData_q;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Bench for data_mem_access_ctrl: two instances (read latency 1 and 3) share one
// byte-array memory; a byte-level reference model predicts every output cycle.
module tb_data_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int MEM_BYTES = 64;

    typedef struct {
        logic        stall;
        logic        done;
        logic        fault;
        logic [1:0]  cause;
        logic        memRd;
        logic        memWr;
        logic        chkAddr;
        logic        chkWdata;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] load;
    } expT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] storeData = 64'd0;
    int          sel = 0;

    logic        rd0, wr0, rd1, wr1;
    logic        stall0, done0, fault0, stall1, done1, fault1;
    logic [1:0]  cause0, cause1;
    logic [63:0] load0, load1;
    logic [63:0] rdData0, rdData1;

    logic        stallS, doneS, faultS, memRdS, memWrS;
    logic [1:0]  causeS;
    logic [63:0] loadS, memAddrS, wdataS;

    logic [7:0]  envMem [0:MEM_BYTES-1];
    logic [7:0]  refMem [0:MEM_BYTES-1];
    logic [63:0] expLoad [0:1];
    expT         expQ [$];

    int          checks = 0;
    int          failures = 0;

    int          stallCnt, rdCnt, wrCnt;
    logic        doneSeen, faultSeen;
    logic [1:0]  lastCause;
    logic [63:0] lastLoad, lastWr, lastRdAddr;

    always #5 clk = ~clk;

    data_mem_access_ctrl_if bus0 ();
    data_mem_access_ctrl_if bus1 ();

    assign rd0 = memRead  && (sel == 0);
    assign wr0 = memWrite && (sel == 0);
    assign rd1 = memRead  && (sel == 1);
    assign wr1 = memWrite && (sel == 1);

    data_mem_access_ctrl #(.READ_LATENCY(1), .MEM_BYTES(MEM_BYTES)) dut0 (
        .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0), .funct3(funct3),
        .Addr(addr), .StoreData(storeData), .Stall(stall0), .Done(done0),
        .LoadData(load0), .Fault(fault0), .FaultCause(cause0), .mem(bus0)
    );

    data_mem_access_ctrl #(.READ_LATENCY(3), .MEM_BYTES(MEM_BYTES)) dut1 (
        .clk(clk), .reset(reset), .MemRead(rd1), .MemWrite(wr1), .funct3(funct3),
        .Addr(addr), .StoreData(storeData), .Stall(stall1), .Done(done1),
        .LoadData(load1), .Fault(fault1), .FaultCause(cause1), .mem(bus1)
    );

    // The memory returns the addressed doubleword combinationally.
    always_comb begin
        rdData0 = 64'd0;
        rdData1 = 64'd0;
        for (int b = 0; b < 8; b++) begin
            rdData0[b*8 +: 8] = envMem[{bus0.Mem_Addr[5:3], 3'(b)}];
            rdData1[b*8 +: 8] = envMem[{bus1.Mem_Addr[5:3], 3'(b)}];
        end
    end

    assign bus0.ReadData = rdData0;
    assign bus1.ReadData = rdData1;

    assign stallS   = (sel == 0) ? stall0 : stall1;
    assign doneS    = (sel == 0) ? done0 : done1;
    assign faultS   = (sel == 0) ? fault0 : fault1;
    assign causeS   = (sel == 0) ? cause0 : cause1;
    assign loadS    = (sel == 0) ? load0 : load1;
    assign memRdS   = (sel == 0) ? bus0.Mem_MemRead : bus1.Mem_MemRead;
    assign memWrS   = (sel == 0) ? bus0.Mem_MemWrite : bus1.Mem_MemWrite;
    assign memAddrS = (sel == 0) ? bus0.Mem_Addr : bus1.Mem_Addr;
    assign wdataS   = (sel == 0) ? bus0.WriteData : bus1.WriteData;

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input expT e);
        checkValue("Stall", 64'(stallS), 64'(e.stall));
        checkValue("Done", 64'(doneS), 64'(e.done));
        checkValue("Fault", 64'(faultS), 64'(e.fault));
        checkValue("FaultCause", 64'(causeS), 64'(e.cause));
        checkValue("Mem_MemRead", 64'(memRdS), 64'(e.memRd));
        checkValue("Mem_MemWrite", 64'(memWrS), 64'(e.memWr));
        checkValue("LoadData", loadS, e.load);
        if (e.chkAddr) checkValue("Mem_Addr", memAddrS, e.addr);
        if (e.chkWdata) checkValue("WriteData", wdataS, e.wdata);
    endtask

    // Load result assembled byte by byte from the reference memory, then extended.
    function automatic logic [63:0] loadValue(input int a, input logic [2:0] f3);
        int size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        v = 64'd0;
        for (int i = 0; i < size; i++) v = v | (64'(refMem[a + i]) << (8 * i));
        if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
        return v;
    endfunction

    function automatic logic [63:0] mergedWord(input int base, input int a, input int size,
                                               input logic [63:0] sd);
        logic [63:0] w;
        w = 64'd0;
        for (int b = 0; b < 8; b++) begin
            if ((base + b >= a) && (base + b < a + size)) w[b*8 +: 8] = sd[(base + b - a)*8 +: 8];
            else w[b*8 +: 8] = refMem[base + b];
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] sd, input int resetAt);
        int lat, size, nCyc, base, aIdx;
        logic [1:0] fc;
        logic isLoad, isSd, doRefStore;
        logic [63:0] newLoad, merged;
        expT e;
        lat = (sel == 0) ? 1 : 3;
        size = 1 << f3[1:0];
        fc = 2'd0;
        if (rd || wr) begin
            if ((rd && wr) || f3 == 3'b111 || (wr && f3[2])) fc = 2'd3;
            else if (a > 64'(MEM_BYTES - size)) fc = 2'd2;
            else if ((a % 64'(size)) != 64'd0) fc = 2'd1;
        end
        isLoad = rd && !wr;
        isSd = wr && !rd && (f3 == 3'b011);
        base = 0;
        aIdx = 0;
        newLoad = 64'd0;
        merged = 64'd0;
        if ((rd || wr) && fc == 2'd0) begin
            aIdx = int'(a[5:0]);
            base = aIdx & ~7;
            newLoad = loadValue(aIdx, f3);
            merged = mergedWord(base, aIdx, size, sd);
        end
        if (!(rd || wr) || fc != 2'd0) nCyc = 1;
        else if (isLoad) nCyc = lat + 2;
        else if (isSd) nCyc = 3;
        else nCyc = lat + 3;

        stallCnt = 0; rdCnt = 0; wrCnt = 0;
        doneSeen = 1'b0; faultSeen = 1'b0; lastCause = 2'd0;
        lastLoad = 64'd0; lastWr = 64'd0; lastRdAddr = 64'd0;

        for (int k = 0; k < nCyc; k++) begin
            @(posedge clk);
            #1;
            e = '{default: '0};
            doRefStore = 1'b0;
            if (resetAt >= 0 && k == resetAt + 1) begin
                reset = 1'b0;
                memRead = 1'b0;
                memWrite = 1'b0;
                expLoad[0] = 64'd0;
                expLoad[1] = 64'd0;
                e.chkAddr = 1'b1;
                e.chkWdata = 1'b1;
                expQ.push_back(e);
                @(negedge clk);
                if (doneS) doneSeen = 1'b1;
                break;
            end
            if (k == 0) begin
                memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd;
            end else begin
                memRead = 1'($urandom_range(0, 1));
                memWrite = 1'($urandom_range(0, 1));
                funct3 = 3'($urandom_range(0, 7));
                addr = {$urandom, $urandom};
                storeData = {$urandom, $urandom};
            end
            reset = (k == resetAt);
            e.load = expLoad[sel];
            if (fc != 2'd0) begin
                e.fault = 1'b1;
                e.cause = fc;
            end else if (rd || wr) begin
                if (k == 0) begin
                    e.stall = 1'b1;
                end else if (k == nCyc - 1) begin
                    e.done = 1'b1;
                    if (isLoad) begin
                        expLoad[sel] = newLoad;
                        e.load = newLoad;
                    end
                end else if (!isSd && k <= lat) begin
                    e.stall = 1'b1; e.memRd = 1'b1; e.chkAddr = 1'b1; e.addr = 64'(base);
                end else begin
                    e.stall = 1'b1; e.memWr = 1'b1; e.chkAddr = 1'b1; e.addr = 64'(base);
                    e.chkWdata = 1'b1; e.wdata = isSd ? sd : merged;
                    doRefStore = 1'b1;
                end
            end
            expQ.push_back(e);
            @(negedge clk);
            if (stallS) stallCnt++;
            if (memRdS) begin rdCnt++; lastRdAddr = memAddrS; end
            if (doneS) begin doneSeen = 1'b1; lastLoad = loadS; end
            if (faultS) begin faultSeen = 1'b1; lastCause = causeS; end
            if (memWrS) begin
                wrCnt++;
                lastWr = wdataS;
                for (int b = 0; b < 8; b++) envMem[{memAddrS[5:3], 3'(b)}] = wdataS[b*8 +: 8];
            end
            if (doRefStore) begin
                for (int i = 0; i < size; i++) refMem[aIdx + i] = sd[i*8 +: 8];
            end
        end
        memRead = 1'b0;
        memWrite = 1'b0;
    endtask

    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic rd, wr;
        logic [2:0] f3;
        logic [63:0] a;
        int size, t, m;
        expT e;

        for (int i = 0; i < MEM_BYTES; i++) begin
            envMem[i] = 8'd0;
            refMem[i] = 8'd0;
        end
        envMem[0] = 8'd3;  refMem[0] = 8'd3;
        envMem[8] = 8'd5;  refMem[8] = 8'd5;
        envMem[16] = 8'd2; refMem[16] = 8'd2;
        envMem[24] = 8'd1; refMem[24] = 8'd1;
        expLoad[0] = 64'd0;
        expLoad[1] = 64'd0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        e = '{default: '0};
        e.chkAddr = 1'b1;
        e.chkWdata = 1'b1;
        expQ.push_back(e);
        @(negedge clk);

        sel = 0;
        applyStimulus(1'b1, 1'b0, F3_LD, 64'h8, 64'h0, -1);
        checkValue("ld8_LoadData", lastLoad, 64'h5);
        checkValue("ld8_stallCycles", 64'(stallCnt), 64'd2);
        checkValue("ld8_readCycles", 64'(rdCnt), 64'd1);
        checkValue("ld8_Mem_Addr", lastRdAddr, 64'h8);

        envMem[15] = 8'h80;
        refMem[15] = 8'h80;
        applyStimulus(1'b1, 1'b0, F3_LB, 64'h0F, 64'h0, -1);
        checkValue("lb0F_LoadData", lastLoad, 64'hFFFF_FFFF_FFFF_FF80);
        applyStimulus(1'b1, 1'b0, F3_LBU, 64'h0F, 64'h0, -1);
        checkValue("lbu0F_LoadData", lastLoad, 64'h0000_0000_0000_0080);

        applyStimulus(1'b0, 1'b1, 3'b000, 64'h11, 64'hAB, -1);
        checkValue("sb11_WriteData", lastWr, 64'h0000_0000_0000_AB02);
        checkValue("sb11_Mem_Addr", lastRdAddr, 64'h10);
        checkValue("sb11_writeCycles", 64'(wrCnt), 64'd1);
        applyStimulus(1'b1, 1'b0, F3_LD, 64'h10, 64'h0, -1);
        checkValue("ld10_LoadData", lastLoad, 64'hAB02);

        applyStimulus(1'b1, 1'b0, F3_LW, 64'h06, 64'h0, -1);
        checkValue("lw06_FaultCause", 64'(lastCause), 64'd1);
        checkValue("lw06_strobes", 64'(rdCnt + wrCnt + stallCnt), 64'd0);
        applyStimulus(1'b1, 1'b0, F3_LD, 64'd64, 64'h0, -1);
        checkValue("ld64_FaultCause", 64'(lastCause), 64'd2);
        applyStimulus(1'b1, 1'b1, F3_LD, 64'h0, 64'h0, -1);
        checkValue("rdwr_FaultCause", 64'(lastCause), 64'd3);

        applyStimulus(1'b0, 1'b1, 3'b011, 64'h18, 64'h1122_3344_5566_7788, -1);
        checkValue("sd18_stallCycles", 64'(stallCnt), 64'd2);
        checkValue("sd18_readCycles", 64'(rdCnt), 64'd0);
        checkValue("sd18_writeCycles", 64'(wrCnt), 64'd1);
        applyStimulus(1'b1, 1'b0, F3_LD, 64'h18, 64'h0, -1);
        checkValue("ld18_LoadData", lastLoad, 64'h1122_3344_5566_7788);

        sel = 1;
        applyStimulus(1'b1, 1'b0, F3_LD, 64'h0, 64'h0, -1);
        checkValue("lat3_readCycles", 64'(rdCnt), 64'd3);
        checkValue("lat3_stallCycles", 64'(stallCnt), 64'd4);
        checkValue("lat3_LoadData", lastLoad, 64'h3);
        applyStimulus(1'b1, 1'b0, F3_LD, 64'h0, 64'h0, 2);
        checkValue("lat3reset_done", 64'(doneSeen), 64'd0);
        checkValue("lat3reset_readCycles", 64'(rdCnt), 64'd2);

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 1));
            t = int'($urandom_range(0, 99));
            rd = 1'b0;
            wr = 1'b0;
            f3 = 3'($urandom_range(0, 7));
            if (t < 45) begin
                rd = 1'b1;
            end else if (t < 85) begin
                wr = 1'b1;
                if ($urandom_range(0, 9) != 0) f3 = 3'($urandom_range(0, 3));
            end else if (t < 90) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            size = 1 << f3[1:0];
            m = int'($urandom_range(0, 99));
            if (m < 70) a = 64'($urandom_range(0, MEM_BYTES / size - 1) * size);
            else if (m < 90) a = 64'($urandom_range(0, 71));
            else a = {$urandom, $urandom};
            applyStimulus(rd, wr, f3, a, {$urandom, $urandom}, -1);
        end

        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
